// File: rtl/fft_ctrl_pkg.sv
// Shared control-path definitions for the iterative FFT sequencer blocks.
// Holds the ring-monitor FSM state type, the ring direction constants and
// a small helper that gives the next legal token position on the ring.
package fft_ctrl_pkg;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } ring_state_e;

  localparam bit SH_LEFT  = 1'b1;
  localparam bit SH_RIGHT = 1'b0;

  // Position the token must move to on a legal step, wrapping at the ring ends
  function automatic int ring_next(input int pos, input int bits, input bit left);
    if (left) begin
      return (pos == bits - 1) ? 0 : pos + 1;
    end
    return (pos == 0) ? bits - 1 : pos - 1;
  endfunction

endpackage

// File: rtl/onehot_encoder.sv
// Combinational one-hot to binary encoder.
// Reports the index of the set bit and whether exactly one bit is set.
// The index is only meaningful while is_onehot is high.
module onehot_encoder #(
  parameter int BITNESS = 16,
  parameter int IDX_W   = (BITNESS > 1) ? $clog2(BITNESS) : 1
) (
  input  logic [BITNESS-1:0] vec,
  output logic [IDX_W-1:0]   idx,
  output logic               is_onehot
);

  // OR together the positions of all set bits; exact for a one-hot input
  always_comb begin
    idx = '0;
    for (int i = 0; i < BITNESS; i++) begin
      if (vec[i]) begin
        idx = idx | IDX_W'(i);
      end
    end
  end

  // Clearing the lowest set bit leaves zero only for a single-bit vector
  assign is_onehot = (vec != '0) && ((vec & (vec - BITNESS'(1))) == '0);

endmodule

// File: rtl/ring_token_monitor.sv
// Reader side of the one-hot ring token that sequences FFT stages.
// Encodes the token position, checks every change is one step in the
// configured direction, pulses o_WRAP on the wrap step and raises a
// sticky fault on a non-one-hot vector or an illegal jump.
// Optional revolution counter: define RING_TOKEN_REV_CNT_EN to build it,
// otherwise o_REV_CNT is tied to zero.
module ring_token_monitor
  import fft_ctrl_pkg::*;
#(
  parameter int BITNESS = 16,
  parameter bit shLeft  = SH_LEFT,
  parameter int IDX_W   = $clog2(BITNESS),
  parameter int REV_W   = 8
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               EN,
  input  logic               CLR,
  input  logic [BITNESS-1:0] i_DATA,
  output logic [IDX_W-1:0]   o_IDX,
  output logic               o_VALID,
  output logic               o_WRAP,
  output logic               o_ERR,
  output logic [REV_W-1:0]   o_REV_CNT
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BITNESS - 1);

  ring_state_e      state;
  logic [IDX_W-1:0] new_idx;
  logic [IDX_W-1:0] fwd_idx;
  logic             is_onehot;
  logic             step_ok;
  logic             wrap_step;

  onehot_encoder #(
    .BITNESS (BITNESS),
    .IDX_W   (IDX_W)
  ) u_enc (
    .vec       (i_DATA),
    .idx       (new_idx),
    .is_onehot (is_onehot)
  );

  // Classify the sampled position against the one legal next position;
  // on a two-bit ring both directions land on the same bit and every move wraps
  always_comb begin
    fwd_idx   = IDX_W'(ring_next(int'(o_IDX), BITNESS, shLeft));
    step_ok   = is_onehot && (new_idx != o_IDX) && (new_idx == fwd_idx);
    wrap_step = step_ok &&
                ((BITNESS == 2) || (shLeft ? (new_idx == '0) : (new_idx == LAST_IDX)));
  end

  // Monitor FSM with all outputs registered; CLR outranks EN, FAULT is sticky
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= SYNC;
      o_IDX   <= '0;
      o_VALID <= 1'b0;
      o_WRAP  <= 1'b0;
      o_ERR   <= 1'b0;
    end else if (CLR) begin
      state   <= SYNC;
      o_VALID <= 1'b0;
      o_WRAP  <= 1'b0;
      o_ERR   <= 1'b0;
    end else if (!EN) begin
      o_WRAP <= 1'b0;
    end else begin
      o_WRAP <= 1'b0;
      case (state)
        SYNC: begin
          if (is_onehot) begin
            state   <= TRACK;
            o_IDX   <= new_idx;
            o_VALID <= 1'b1;
          end else begin
            state   <= FAULT;
            o_VALID <= 1'b0;
            o_ERR   <= 1'b1;
          end
        end
        TRACK: begin
          if (is_onehot && (new_idx == o_IDX)) begin
            state <= TRACK;
          end else if (step_ok) begin
            o_IDX  <= new_idx;
            o_WRAP <= wrap_step;
          end else begin
            state   <= FAULT;
            o_VALID <= 1'b0;
            o_ERR   <= 1'b1;
          end
        end
        FAULT: begin
          o_VALID <= 1'b0;
          o_ERR   <= 1'b1;
        end
        default: begin
          state   <= SYNC;
          o_VALID <= 1'b0;
        end
      endcase
    end
  end

`ifdef RING_TOKEN_REV_CNT_EN
  logic [REV_W-1:0] rev_cnt;

  // Count completed revolutions on every legal wrap step, modulo 2^REV_W
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rev_cnt <= '0;
    end else if (CLR) begin
      rev_cnt <= '0;
    end else if (EN && (state == TRACK) && wrap_step) begin
      rev_cnt <= rev_cnt + 1'b1;
    end
  end

  assign o_REV_CNT = rev_cnt;
`else
  assign o_REV_CNT = '0;
`endif

endmodule

// File: tb/tb_ring_token_monitor.sv
// Self-checking bench for ring_token_monitor.
// Three instances: 4-bit left ring, 4-bit right ring and 2-bit ring.
// A behavioural model runs alongside each instance; its predicted outputs
// are queued when a cycle is driven and popped after the clock edge.
module tb_ring_token_monitor;

  typedef struct packed {
    int st;
    int idx;
    bit valid;
    bit wrap;
    bit err;
    int rev;
  } mdl_t;

  typedef struct packed {
    logic [1:0] idx;
    logic       valid;
    logic       wrap;
    logic       err;
    logic [7:0] rev;
  } obs_t;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       en  [3];
  logic       clr [3];
  logic [3:0] din [3];

  logic [1:0] idxL, idxR;
  logic       idx2;
  logic       vL, vR, v2, wL, wR, w2, eL, eR, e2;
  logic [7:0] rL, rR, r2;

  int   BITS [3] = '{4, 4, 2};
  bit   LEFT [3] = '{1'b1, 1'b0, 1'b1};
  mdl_t mdl  [3];
  obs_t exp_q[$];

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  ring_token_monitor #(.BITNESS(4), .shLeft(1'b1), .REV_W(8)) dutL (
    .CLK(CLK), .RST_N(RST_N), .EN(en[0]), .CLR(clr[0]), .i_DATA(din[0]),
    .o_IDX(idxL), .o_VALID(vL), .o_WRAP(wL), .o_ERR(eL), .o_REV_CNT(rL)
  );

  ring_token_monitor #(.BITNESS(4), .shLeft(1'b0), .REV_W(8)) dutR (
    .CLK(CLK), .RST_N(RST_N), .EN(en[1]), .CLR(clr[1]), .i_DATA(din[1]),
    .o_IDX(idxR), .o_VALID(vR), .o_WRAP(wR), .o_ERR(eR), .o_REV_CNT(rR)
  );

  ring_token_monitor #(.BITNESS(2), .shLeft(1'b1), .REV_W(8)) dut2 (
    .CLK(CLK), .RST_N(RST_N), .EN(en[2]), .CLR(clr[2]), .i_DATA(din[2][1:0]),
    .o_IDX(idx2), .o_VALID(v2), .o_WRAP(w2), .o_ERR(e2), .o_REV_CNT(r2)
  );

  // Behavioural model of one monitor: one call per clock edge
  function automatic mdl_t model_step(mdl_t m, int bits, bit left, logic [3:0] d, bit e, bit c);
    mdl_t r;
    int   ones;
    int   pos;
    int   nxt;
    bit   wr;
    r      = m;
    r.wrap = 1'b0;
    if (c) begin
      r.st = 0; r.err = 1'b0; r.valid = 1'b0; r.rev = 0;
      return r;
    end
    if (!e) return r;
    ones = 0;
    pos  = 0;
    for (int i = 0; i < bits; i++) begin
      if (d[i]) begin
        ones++;
        pos = i;
      end
    end
    if (m.st == 0) begin
      if (ones == 1) begin
        r.st = 1; r.idx = pos; r.valid = 1'b1;
      end else begin
        r.st = 2; r.err = 1'b1; r.valid = 1'b0;
      end
    end else if (m.st == 1) begin
      nxt = left ? (m.idx + 1) % bits : (m.idx + bits - 1) % bits;
      if (ones == 1 && pos == m.idx) begin
        r.idx = m.idx;
      end else if (ones == 1 && pos == nxt) begin
        wr     = (bits == 2) || (left ? (pos == 0) : (pos == bits - 1));
        r.idx  = pos;
        r.wrap = wr;
`ifdef RING_TOKEN_REV_CNT_EN
        if (wr) r.rev = (m.rev + 1) % 256;
`endif
      end else begin
        r.st = 2; r.err = 1'b1; r.valid = 1'b0;
      end
    end
    return r;
  endfunction

  function automatic obs_t to_obs(mdl_t m);
    return '{idx: 2'(m.idx), valid: m.valid, wrap: m.wrap, err: m.err, rev: 8'(m.rev)};
  endfunction

  function automatic obs_t observe(int s);
    case (s)
      0:       return '{idx: idxL, valid: vL, wrap: wL, err: eL, rev: rL};
      1:       return '{idx: idxR, valid: vR, wrap: wR, err: eR, rev: rR};
      default: return '{idx: {1'b0, idx2}, valid: v2, wrap: w2, err: e2, rev: r2};
    endcase
  endfunction

  // Drive one cycle into instance s (others idle), advance every model, queue the prediction
  task automatic applyStimulus(input int s, input logic [3:0] d, input logic e, input logic c);
    @(negedge CLK);
    for (int k = 0; k < 3; k++) begin
      en[k]  = (k == s) ? e : 1'b0;
      clr[k] = (k == s) ? c : 1'b0;
      if (k == s) din[k] = d;
      mdl[k] = model_step(mdl[k], BITS[k], LEFT[k], din[k], en[k], clr[k]);
    end
    exp_q.push_back(to_obs(mdl[s]));
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    obs_t e, o;
    #12;
    for (int s = 0; s < 3; s++) exp_q.push_back('0);
    for (int s = 0; s < 3; s++) begin
      e = exp_q.pop_front();
      o = observe(s);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset dut%0d got %h want %h", s, o, e);
      end
    end
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic test_sequence();
    logic [3:0] seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    int         want [5] = '{0, 1, 2, 3, 0};
    int         wraps = 0;
    obs_t       e, o;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, seq[i], 1'b1, 1'b0);
      e = exp_q.pop_front();
      o = observe(0);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL sequence step%0d got %h want %h", i, o, e);
      end
      checks++;
      if (int'(idxL) !== want[i] || vL !== 1'b1) begin
        errors++;
        $display("FAIL sequence_idx step%0d got idx=%0d v=%0b want idx=%0d v=1", i, idxL, vL, want[i]);
      end
      if (wL) wraps++;
    end
    checks++;
    if (wraps !== 1) begin
      errors++;
      $display("FAIL sequence_wraps got %0d want 1", wraps);
    end
  endtask

  task automatic test_stall();
    logic [3:0] seq [7] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0100};
    obs_t       e, o;
    for (int i = 0; i < 7; i++) begin
      applyStimulus(0, seq[i], 1'b1, 1'b0);
      e = exp_q.pop_front();
      o = observe(0);
      checks++;
      if (o !== e || eL !== 1'b0) begin
        errors++;
        $display("FAIL stall step%0d got %h want %h", i, o, e);
      end
    end
  endtask

  task automatic test_jump();
    logic [3:0] seq [6] = '{4'b0010, 4'b0010, 4'b1000, 4'b0100, 4'b1000, 4'b0010};
    logic       cl  [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    obs_t       e, o;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, seq[i], 1'b1, cl[i]);
      e = exp_q.pop_front();
      o = observe(0);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL jump step%0d got %h want %h", i, o, e);
      end
      if (i == 4) begin
        checks++;
        if (eL !== 1'b1 || vL !== 1'b0 || idxL !== 2'd1) begin
          errors++;
          $display("FAIL jump_sticky got e=%0b v=%0b idx=%0d want e=1 v=0 idx=1", eL, vL, idxL);
        end
      end
    end
    checks++;
    if (eL !== 1'b0 || vL !== 1'b0) begin
      errors++;
      $display("FAIL jump_clr got e=%0b v=%0b want e=0 v=0", eL, vL);
    end
  endtask

  task automatic test_not_onehot();
    logic [3:0] seq [5] = '{4'b0110, 4'b0001, 4'b0001, 4'b0000, 4'b0001};
    logic       cl  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    obs_t       e, o;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, seq[i], 1'b1, cl[i]);
      e = exp_q.pop_front();
      o = observe(0);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL not_onehot step%0d got %h want %h", i, o, e);
      end
    end
    checks++;
    if (eL !== 1'b1) begin
      errors++;
      $display("FAIL not_onehot_err got %0b want 1", eL);
    end
  endtask

  task automatic test_enable();
    logic [3:0] seq [7] = '{4'b0100, 4'b0100, 4'b1000, 4'b0001, 4'b0110, 4'b0010, 4'b0010};
    logic       cl  [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       ev  [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    obs_t       e, o;
    for (int i = 0; i < 7; i++) begin
      applyStimulus(0, seq[i], ev[i], cl[i]);
      e = exp_q.pop_front();
      o = observe(0);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL enable step%0d got %h want %h", i, o, e);
      end
      if (i == 4) begin
        checks++;
        if (wL !== 1'b0 || eL !== 1'b0 || idxL !== 2'd0) begin
          errors++;
          $display("FAIL enable_hold got w=%0b e=%0b idx=%0d want w=0 e=0 idx=0", wL, eL, idxL);
        end
      end
    end
  endtask

  task automatic test_shift_right();
    logic [3:0] seq [6] = '{4'b0001, 4'b1000, 4'b0100, 4'b0001, 4'b0001, 4'b0010};
    logic       cl  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    obs_t       e, o;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, seq[i], 1'b1, cl[i]);
      e = exp_q.pop_front();
      o = observe(1);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL shift_right step%0d got %h want %h", i, o, e);
      end
      if (i == 1) begin
        checks++;
        if (wR !== 1'b1 || idxR !== 2'd3) begin
          errors++;
          $display("FAIL shift_right_wrap got w=%0b idx=%0d want w=1 idx=3", wR, idxR);
        end
      end
    end
    checks++;
    if (eR !== 1'b1) begin
      errors++;
      $display("FAIL shift_right_wrongdir got e=%0b want 1", eR);
    end
  endtask

  task automatic test_two_bit();
    logic [3:0] seq [6] = '{4'b0001, 4'b0010, 4'b0001, 4'b0001, 4'b0010, 4'b0011};
    obs_t       e, o;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(2, seq[i], 1'b1, 1'b0);
      e = exp_q.pop_front();
      o = observe(2);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL two_bit step%0d got %h want %h", i, o, e);
      end
    end
  endtask

  task automatic test_revolutions();
    logic [3:0] ring [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    int         wraps = 0;
    obs_t       e, o;
    applyStimulus(0, 4'b0001, 1'b1, 1'b1);
    void'(exp_q.pop_front());
    applyStimulus(0, 4'b0001, 1'b1, 1'b0);
    void'(exp_q.pop_front());
    for (int i = 0; i < 256 * 4; i++) begin
      applyStimulus(0, ring[i % 4], 1'b1, 1'b0);
      e = exp_q.pop_front();
      o = observe(0);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL revolutions cyc%0d got %h want %h", i, o, e);
      end
      if (wL) wraps++;
      if (i == 7) begin
        checks++;
`ifdef RING_TOKEN_REV_CNT_EN
        if (rL !== 8'd2) begin
`else
        if (rL !== 8'd0) begin
`endif
          errors++;
          $display("FAIL rev_count_two got %0d", rL);
        end
      end
    end
    checks++;
    if (wraps !== 256 || rL !== 8'd0) begin
      errors++;
      $display("FAIL rev_rollover got wraps=%0d rev=%0d want wraps=256 rev=0", wraps, rL);
    end
    applyStimulus(0, 4'b0010, 1'b1, 1'b0);
    void'(exp_q.pop_front());
    applyStimulus(0, 4'b0100, 1'b1, 1'b1);
    e = exp_q.pop_front();
    o = observe(0);
    checks++;
    if (o !== e || vL !== 1'b0 || idxL !== 2'd1) begin
      errors++;
      $display("FAIL clr_wins got %h want %h", o, e);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, ring[(i + 3) % 4], 1'b1, 1'b0);
      void'(exp_q.pop_front());
    end
    #2;
    RST_N = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) mdl[k] = '0;
    exp_q.push_back('0);
    e = exp_q.pop_front();
    o = observe(0);
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL async_reset got %h want %h", o, e);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    applyStimulus(0, 4'b0100, 1'b1, 1'b0);
    e = exp_q.pop_front();
    o = observe(0);
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL after_reset got %h want %h", o, e);
    end
  endtask

  initial begin
    RST_N = 1'b0;
    for (int k = 0; k < 3; k++) begin
      en[k]  = 1'b0;
      clr[k] = 1'b0;
      din[k] = 4'b0000;
      mdl[k] = '0;
    end
    test_reset();
    test_sequence();
    test_stall();
    test_jump();
    test_not_onehot();
    test_enable();
    test_shift_right();
    test_two_bit();
    test_revolutions();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ring_token_monitor.md
Name: ring_token_monitor

Overview:
- Reader side of the one-hot ring token used to sequence stages/butterfly groups in the iterative FFT.
- Samples the ring vector every enabled cycle and encodes the single set bit to a binary index.
- Checks that each change is exactly one legal step in the configured shift direction and pulses on wrap-around.
- Raises a sticky fault on a non-one-hot vector or an illegal jump; counts full revolutions (optional).

Parameters:
- BITNESS, 16: width of the monitored ring vector; must be >= 2.
- shLeft, 1: expected direction. 1 = bit i moves to i+1 and wraps BITNESS-1 -> 0. 0 = bit i moves to i-1 and wraps 0 -> BITNESS-1.
- IDX_W, $clog2(BITNESS): width of o_IDX.
- REV_W, 8: width of the revolution counter.

Ports:
- CLK, in, 1: clock; all state updates on the rising edge.
- RST_N, in, 1: asynchronous active-low reset.
- EN, in, 1: monitor enable; when low, the vector is not sampled and all state holds.
- CLR, in, 1: synchronous clear of fault and revolution count; returns the FSM to SYNC.
- i_DATA, in, BITNESS: ring vector under observation.
- o_IDX, out, IDX_W: encoded position of the token.
- o_VALID, out, 1: o_IDX is trustworthy (FSM in TRACK).
- o_WRAP, out, 1: one-cycle pulse on a legal wrap step.
- o_ERR, out, 1: sticky fault flag.
- o_REV_CNT, out, REV_W: completed revolutions, modulo 2^REV_W.

Behaviour:
- Reset (RST_N low, asynchronous): FSM = SYNC; o_IDX = 0; o_VALID = 0; o_WRAP = 0; o_ERR = 0; o_REV_CNT = 0.
- All outputs are registered. Latency is 1 cycle from i_DATA sampled at edge k to outputs valid after edge k.
- one-hot check (combinational): exactly one bit of i_DATA is set.
- SYNC state, on an EN edge:
  - one-hot -> load o_IDX, go to TRACK, o_VALID = 1.
  - not one-hot -> go to FAULT, o_ERR = 1.
- TRACK state, on an EN edge, with prev = o_IDX and new = encoded i_DATA:
  - not one-hot -> FAULT.
  - new == prev -> hold; the ring is allowed to stall.
  - new == prev±1 modulo BITNESS, in the shLeft direction -> o_IDX <= new.
  - Any other new -> FAULT; this includes a step in the wrong direction.
- Wrap step: the legal step BITNESS-1 -> 0 (shLeft = 1) or 0 -> BITNESS-1 (shLeft = 0).
  - o_WRAP = 1 for exactly one cycle.
  - o_REV_CNT increments, modulo 2^REV_W.
- The first index loaded from SYNC never produces o_WRAP.
- FAULT state:
  - o_VALID = 0; o_ERR = 1 and sticky.
  - o_IDX holds its last value; o_WRAP = 0.
  - Leaves FAULT only on CLR or reset.
- CLR: takes priority over EN in the same cycle. Result: FSM = SYNC, o_ERR = 0, o_REV_CNT = 0, o_WRAP = 0, o_VALID = 0. o_IDX holds.
- EN low: no sampling; o_WRAP deasserts; all other state holds.
- Reset mid-operation returns immediately to the reset values.
- BITNESS == 2: +1 and -1 are the same position, so both directions are legal. Every change is a wrap step.

Optional Feature:
- Macro: RING_TOKEN_REV_CNT_EN.
- Defined: revolution counter as described above.
- Undefined: no counter register; o_REV_CNT is tied to 0. o_WRAP is unaffected.

Decomposition:
- Shared package (fft_ctrl_pkg):
  - FSM state typedef with values SYNC = 2'd0, TRACK = 2'd1, FAULT = 2'd2.
  - Direction constants SH_LEFT = 1, SH_RIGHT = 0.
- One natural sub-module: onehot_encoder.
  - Purely combinational; parameter BITNESS.
  - Outputs the index and an is_onehot flag.
  - Reusable by other control blocks.

Test Plan (BITNESS = 4, shLeft = 1 unless noted):
1. Reset, EN = 1, feed 0001, 0010, 0100, 1000, 0001. Expected:
   - o_IDX = 0, 1, 2, 3, 0 (one cycle after each sample).
   - o_VALID = 1 from the first sample.
   - o_WRAP pulses once on the 3 -> 0 step.
   - o_REV_CNT = 1.
2. In TRACK at 0010, hold 0010 for 5 cycles, then apply 0100. Expected: no o_ERR, o_IDX = 1 throughout the hold, then 2.
3. In TRACK at 0010, apply 1000 (a jump of 2). Expected:
   - o_ERR = 1 and o_VALID = 0 the next cycle.
   - o_IDX stays 1.
   - Both remain after further legal vectors.
   - CLR restores SYNC with o_ERR = 0.
4. Apply 0110 in SYNC, and separately apply 0000 in TRACK. Expected: FAULT in both cases, o_ERR = 1.
5. shLeft = 0: feed 0001 then 1000. Expected: legal wrap, o_WRAP = 1, o_IDX = 3. Feeding 0010 after 0001 faults.
6. Run 256 full revolutions with REV_W = 8. Expected:
   - o_REV_CNT wraps to 0.
   - CLR and EN asserted together: CLR wins.
   - Asynchronous RST_N low mid-run: outputs zero immediately.
   - With RING_TOKEN_REV_CNT_EN undefined: o_REV_CNT = 0 always.
